// File: rtl/de0_cv_fifo.sv
// Single-clock first-word fall-through FIFO behind the DE0_CV board wrapper.
// Define DE0_CV_FIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs.
module de0_cv_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             m_clock,
  input  logic             p_reset,
  input  logic [WIDTH-1:0] in,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] out,
  output logic             is_empty,
  output logic             is_full,
`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign is_empty = (count == '0);
  assign is_full  = (count == FULL_CNT);
  // A pop on full frees the slot the simultaneous push lands in.
  assign do_push  = push & (~is_full | pop);
  assign do_pop   = pop & ~is_empty;
  assign out      = is_empty ? '0 : mem[rptr];

  always_ff @(posedge m_clock) begin
    if (do_push) mem[wptr] <= in;
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && is_full && !pop) overflow  <= 1'b1;
      if (pop && is_empty)         underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_de0_cv_fifo.sv
// Directed bench for de0_cv_fifo: vector table for basic ordering plus
// hand-written sequences for reset, full, simultaneous and wrap corners.
module tb_de0_cv_fifo;

  logic       m_clock = 1'b0;
  logic       p_reset = 1'b0;
  logic [7:0] in      = '0;
  logic       push    = 1'b0;
  logic       pop     = 1'b0;
  logic [7:0] out;
  logic       is_empty, is_full;
  logic [4:0] count;
`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int checks   = 0;
  int failures = 0;

  de0_cv_fifo #(.WIDTH(8), .DEPTH(16)) dut (
    .m_clock  (m_clock),
    .p_reset  (p_reset),
    .in       (in),
    .push     (push),
    .pop      (pop),
    .out      (out),
    .is_empty (is_empty),
    .is_full  (is_full),
`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .count    (count)
  );

  always #5 m_clock = ~m_clock;

  typedef struct {
    logic       push;
    logic       pop;
    logic [7:0] din;
    logic [7:0] eout;
    logic [4:0] ecnt;
    logic       eempty;
    logic       efull;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string name, input logic [7:0] eout, input logic [4:0] ecnt);
    chk({name, ".out"},   32'(out), 32'(eout));
    chk({name, ".count"}, 32'(count), 32'(ecnt));
    chk({name, ".empty"}, 32'(is_empty), 32'(ecnt == 5'd0));
    chk({name, ".full"},  32'(is_full), 32'(ecnt == 5'd16));
  endtask

  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic cycle(input logic ps, input logic pp, input logic [7:0] d);
    push = ps; pop = pp; in = d;
    @(posedge m_clock);
    #1;
    push = 1'b0; pop = 1'b0; in = '0;
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 8'd7, 8'd7, 5'd1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'd2, 8'd7, 5'd2, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 8'd3, 8'd7, 5'd3, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 8'd0, 8'd2, 5'd2, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 8'd0, 8'd3, 5'd1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'd0, 8'd0, 5'd0, 1'b1, 1'b0};

    // Reset state
    #3;
    chk_state("reset", 8'd0, 5'd0);
`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
    chk("reset.overflow", 32'(overflow), 32'd0);
    chk("reset.underflow", 32'(underflow), 32'd0);
`endif
    #4 p_reset = 1'b1;

    // Basic order from the vector table
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].push, vecs[i].pop, vecs[i].din);
      chk($sformatf("vec%0d.out", i),   32'(out),      32'(vecs[i].eout));
      chk($sformatf("vec%0d.count", i), 32'(count),    32'(vecs[i].ecnt));
      chk($sformatf("vec%0d.empty", i), 32'(is_empty), 32'(vecs[i].eempty));
      chk($sformatf("vec%0d.full", i),  32'(is_full),  32'(vecs[i].efull));
    end

    // Pop on empty is ignored
    for (int i = 0; i < 30; i++) cycle(1'b0, 1'b1, 8'd0);
    chk_state("pop_empty", 8'd0, 5'd0);
`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
    chk("pop_empty.underflow", 32'(underflow), 32'd1);
    chk("pop_empty.overflow", 32'(overflow), 32'd0);
`endif

    // Asynchronous reset mid-run with count=3
    cycle(1'b1, 1'b0, 8'h21);
    cycle(1'b1, 1'b0, 8'h22);
    cycle(1'b1, 1'b0, 8'h23);
    chk_state("pre_reset", 8'h21, 5'd3);
    #2 p_reset = 1'b0;
    #1;
    chk_state("async_reset", 8'd0, 5'd0);
`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
    chk("async_reset.underflow", 32'(underflow), 32'd0);
`endif
    #2 p_reset = 1'b1;
    @(posedge m_clock);
    #1;
    chk_state("post_reset", 8'd0, 5'd0);

    // Fill to full
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 8'(8'h10 + i));
      chk($sformatf("fill%0d.count", i), 32'(count), 32'(i + 1));
    end
    chk_state("full", 8'h10, 5'd16);

    // Push on full without pop is dropped
    cycle(1'b1, 1'b0, 8'hAA);
    chk_state("push_full", 8'h10, 5'd16);
`ifdef DE0_CV_FIFO_ERR_FLAGS_EN
    chk("push_full.overflow", 32'(overflow), 32'd1);
`endif

    // Push+pop on full: both accepted
    cycle(1'b1, 1'b1, 8'h55);
    chk_state("pushpop_full", 8'h11, 5'd16);

    // Drain: 0x11..0x1F then 0x55
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d.out", i), 32'(out), (i < 15) ? 32'(8'h11 + i) : 32'h55);
      cycle(1'b0, 1'b1, 8'd0);
    end
    chk_state("drained", 8'd0, 5'd0);

    // Push+pop on empty: push accepted, pop ignored
    cycle(1'b1, 1'b1, 8'h99);
    chk_state("pushpop_empty", 8'h99, 5'd1);
    cycle(1'b0, 1'b1, 8'd0);
    chk_state("pop_99", 8'd0, 5'd0);

    // Wrap-around: prefill 5, then 40 push/pop pairs, then drain 5
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'(100 + i));
    chk("wrap_pre.count", 32'(count), 32'd5);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("wrap%0d.out", i), 32'(out), (i < 5) ? 32'(100 + i) : 32'(i - 5));
      cycle(1'b1, 1'b1, 8'(i));
      chk($sformatf("wrap%0d.count", i), 32'(count), 32'd5);
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("wrap_tail%0d.out", i), 32'(out), 32'(35 + i));
      cycle(1'b0, 1'b1, 8'd0);
    end
    chk_state("wrap_end", 8'd0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
